// File: rtl/uart_rx.sv
// uart_rx - 16x-oversampled UART receiver, 8 data bits, LSB first,
// with an optional odd parity bit and one stop bit (8N1 / 8O1).
//
// Ports:
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   tick_16x      one-clk enable pulse at 16x the baud rate; all bit timing
//                 counts these pulses
//   rx_pin        serial input, idle high, LSB first
//   parity_enable 1 = an odd parity bit follows the data bits
//   rx_data       last received byte
//   data_ready    one-clk pulse when a frame completes
//   parity_err    parity status of the last frame
//   frame_err     stop-bit status of the last frame
//
// rx_state and os_count are kept under those names so they can be probed
// while debugging.

module uart_rx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_16x,
  input  logic       rx_pin,
  input  logic       parity_enable,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  rx_state_t  rx_state;
  logic [3:0] os_count;

  logic       sync1_r;
  logic       sync2_r;
  logic [7:0] shift_r;
  logic [2:0] bit_idx_r;
  logic       parity_en_r;   // parity_enable captured when DATA completes
  logic       parity_bad_r;  // parity mismatch of the current frame
  logic       break_wait_r;  // line was low at the stop bit; wait for idle
  logic       rx_s;
  logic       mid_bit_s;

  // Odd parity: the bit that makes data plus parity hold an odd count of 1s.
  function automatic logic odd_parity_bit(input logic [7:0] data);
    return ~^data;
  endfunction

  // Two-flop synchroniser for the asynchronous pad input; idles high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_pin;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s      = sync2_r;
  // The 16th tick of a bit period lands mid-bit because START already
  // consumed half a bit before handing over to DATA.
  assign mid_bit_s = (os_count == 4'd15);

  // Receive FSM: state, oversample counter, shift register and outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state     <= IDLE;
      os_count     <= 4'd0;
      shift_r      <= 8'h00;
      bit_idx_r    <= 3'd0;
      parity_en_r  <= 1'b0;
      parity_bad_r <= 1'b0;
      break_wait_r <= 1'b0;
      rx_data      <= 8'h00;
      data_ready   <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      // data_ready is the only thing that moves without a tick.
      data_ready <= 1'b0;
      if (tick_16x) begin
        case (rx_state)
          IDLE: begin
            os_count <= 4'd0;
            if (break_wait_r) begin
              // After a break, only a return to idle re-arms start detection.
              if (rx_s) begin
                break_wait_r <= 1'b0;
              end
            end else if (!rx_s) begin
              rx_state <= START;
            end
          end

          START: begin
            if (os_count == 4'd7) begin
              os_count <= 4'd0;
              if (rx_s) begin
                // Glitch shorter than half a bit: not a real start bit.
                rx_state <= IDLE;
              end else begin
                bit_idx_r <= 3'd0;
                rx_state  <= DATA;
              end
            end else begin
              os_count <= os_count + 4'd1;
            end
          end

          DATA: begin
            os_count <= os_count + 4'd1;  // wraps 15 -> 0 each bit
            if (mid_bit_s) begin
              shift_r <= {rx_s, shift_r[7:1]};
              if (bit_idx_r == 3'd7) begin
                parity_en_r <= parity_enable;
                rx_state    <= parity_enable ? PARITY : STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end
          end

          PARITY: begin
            os_count <= os_count + 4'd1;
            if (mid_bit_s) begin
              parity_bad_r <= (rx_s != odd_parity_bit(shift_r));
              rx_state     <= STOP;
            end
          end

          STOP: begin
            if (mid_bit_s) begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              os_count     <= 4'd0;
              rx_data      <= shift_r;
              frame_err    <= ~rx_s;
              parity_err   <= parity_en_r & parity_bad_r;
              data_ready   <= 1'b1;
              break_wait_r <= ~rx_s;
              rx_state     <= IDLE;
            end else begin
              os_count <= os_count + 4'd1;
            end
          end

          default: begin
            os_count <= 4'd0;
            rx_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, expected results queued when each
// frame is sent and checked by an independent monitor on every data_ready.

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_16x = 1'b0;
  logic       rx_pin = 1'b1;
  logic       parity_enable = 1'b0;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_count = 0;
  logic prev_ready = 1'b0;

  uart_rx dut (
    .clk          (clk),
    .resetn       (resetn),
    .tick_16x     (tick_16x),
    .rx_pin       (rx_pin),
    .parity_enable(parity_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // tick_16x: one clk wide, every 4 clks, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick_16x = 1'b1;
      @(negedge clk);
      tick_16x = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every data_ready pops one expected frame and compares it.
  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      ready_count++;
      check("ready_width", {31'd0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got frame 0x%0h expected none", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.d});
        check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
        check("frame_err", {31'd0, frame_err}, {31'd0, mon_e.fe});
      end
    end
    prev_ready = data_ready;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick_16x !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_pin = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (par_en) send_bit(par_bit);
    send_bit(stop_bit);
    rx_pin = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_state(input string name);
    check({name, "_state"}, {29'd0, dut.rx_state}, 32'd0);
    check({name, "_os_count"}, {28'd0, dut.os_count}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({name, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    check({name, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check_idle_state(name);
  endtask

  initial begin
    // Reset state.
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    wait_ticks(16);

    // 0x4E with correct odd parity (four 1s -> parity bit 1).
    parity_enable = 1'b1;
    expect_frame(8'h4E, 1'b0, 1'b0);
    send_frame(8'h4E, 1'b1, 1'b1, 1'b1);
    check("ready_count_4e", ready_count, 32'd1);
    wait_ticks(34);
    check("ready_count_4e_quiet", ready_count, 32'd1);
    check("hold_rx_data", {24'd0, rx_data}, 32'h4E);

    // Same byte, wrong parity bit.
    expect_frame(8'h4E, 1'b1, 1'b0);
    send_frame(8'h4E, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check("ready_count_parerr", ready_count, 32'd2);

    // 0xA5, good parity, stop bit held low (framing error / break).
    expect_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_ticks(20);
    check("ready_count_framerr", ready_count, 32'd3);
    check_idle_state("after_break");

    // No parity, back-to-back 0x3C then 0xC3.
    parity_enable = 1'b0;
    expect_frame(8'h3C, 1'b0, 1'b0);
    expect_frame(8'hC3, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    check("ready_count_b2b", ready_count, 32'd5);

    // False start: low for only 4 ticks.
    rx_pin = 1'b0;
    wait_ticks(4);
    rx_pin = 1'b1;
    wait_ticks(24);
    check("ready_count_false_start", ready_count, 32'd5);
    check_idle_state("false_start");

    // Reset during data bit 3 of a 0x4E frame.
    parity_enable = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_pin = 1'b1;
    wait_ticks(8);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_ticks(16);
    expect_frame(8'h4E, 1'b0, 1'b0);
    send_frame(8'h4E, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    check("ready_count_after_reset", ready_count, 32'd6);
    check("exp_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
